// File: rtl/wb_bridge_pkg.sv
// Shared types and constants for the picorv32 -> Wishbone B4 bridge.
package wb_bridge_pkg;

  typedef enum logic [1:0] {IDLE, REQ, BACKOFF, DONE} state_e;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_ERR  = 2'd1;
  localparam logic [1:0] CAUSE_RTY  = 2'd2;
  localparam logic [1:0] CAUSE_TMO  = 2'd3;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_bridge_timer.sv
// Loadable down-counter shared by the bus timeout and the retry back-off.
// tc_o is high while the count sits at zero; the count never wraps below it.
module wb_bridge_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)            cnt_q <= '0;
    else if (load_i)               cnt_q <= load_val_i;
    else if (en_i && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/picorv32_wb_bridge.sv
// picorv32 native memory port to Wishbone B4 classic single-access master with
// ERR/RTY handling, retry back-off, timeout and error capture. Optional
// counters enabled by defining WB_BRIDGE_STATS_EN.
module picorv32_wb_bridge
  import wb_bridge_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          MAX_RETRY      = 3,
  parameter int          RETRY_GAP      = 4,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF,
  localparam int         SEL_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [SEL_WIDTH-1:0]  mem_wstrb,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  input  logic [DATA_WIDTH-1:0] wbm_dat_i,
  output logic                  wbm_we_o,
  output logic [SEL_WIDTH-1:0]  wbm_sel_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_cyc_o,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  input  logic                  wbm_rty_i,
  output logic                  bus_err,
  output logic [1:0]            err_cause,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_instr
`ifdef WB_BRIDGE_STATS_EN
  ,
  output logic [31:0]           stat_xfer_cnt,
  output logic [15:0]           stat_err_cnt
`endif
);

  localparam int TW0 = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW1 = $clog2(RETRY_GAP + 1);
  localparam int TW  = (TW0 > TW1) ? TW0 : TW1;
  localparam int RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  // Loaded value N-1 means the Nth cycle is the one that sees tc.
  localparam logic [TW-1:0] TMO_LOAD = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [TW-1:0] GAP_LOAD = TW'(RETRY_GAP - 1);
  localparam logic [DATA_WIDTH-1:0] ERR_D = DATA_WIDTH'(ERR_RDATA);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, eaddr_q, eaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  we_q, we_d, instr_q, instr_d, einstr_q, einstr_d;
  logic                  ready_q, ready_d, bus_err_q, bus_err_d;
  logic [1:0]            cause_q, cause_d, fail_cause;
  logic [RW-1:0]         rcnt_q, rcnt_d;
  logic                  fail;
  logic                  tmr_clr, tmr_load, tmr_en, tmr_tc;
  logic [TW-1:0]         tmr_load_val;

  wb_bridge_timer #(.W(TW)) u_timer (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .en_i       (tmr_en),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    we_d         = we_q;
    instr_d      = instr_q;
    rcnt_d       = rcnt_q;
    rdata_d      = rdata_q;
    ready_d      = 1'b0;
    bus_err_d    = 1'b0;
    cause_d      = cause_q;
    eaddr_d      = eaddr_q;
    einstr_d     = einstr_q;
    tmr_clr      = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = TMO_LOAD;
    tmr_en       = 1'b0;
    fail         = 1'b0;
    fail_cause   = CAUSE_NONE;
    unique case (state_q)
      IDLE: if (mem_valid) begin
        addr_d   = mem_addr;
        wdata_d  = mem_wdata;
        we_d     = |mem_wstrb;
        sel_d    = (|mem_wstrb) ? mem_wstrb : '1;
        instr_d  = mem_instr;
        rcnt_d   = '0;
        tmr_load = 1'b1;
        state_d  = REQ;
      end
      REQ: begin
        if (wbm_ack_i) begin
          rdata_d = we_q ? '0 : wbm_dat_i;
          ready_d = 1'b1;
          state_d = DONE;
        end else if (wbm_err_i) begin
          fail       = 1'b1;
          fail_cause = CAUSE_ERR;
        end else if (wbm_rty_i) begin
          if (rcnt_q < RW'(MAX_RETRY)) begin
            rcnt_d       = rcnt_q + 1'b1;
            tmr_load     = 1'b1;
            tmr_load_val = GAP_LOAD;
            state_d      = BACKOFF;
          end else begin
            fail       = 1'b1;
            fail_cause = CAUSE_RTY;
          end
        end else if (TIMEOUT_CYCLES != 0 && tmr_tc) begin
          fail       = 1'b1;
          fail_cause = CAUSE_TMO;
        end else begin
          tmr_en = 1'b1;
        end
      end
      BACKOFF: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          state_d  = REQ;
        end else begin
          tmr_en = 1'b1;
        end
      end
      DONE: begin
        tmr_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // All failure causes complete the access the same way.
    if (fail) begin
      rdata_d   = ERR_D;
      ready_d   = 1'b1;
      bus_err_d = 1'b1;
      cause_d   = fail_cause;
      eaddr_d   = addr_q;
      einstr_d  = instr_q;
      state_d   = DONE;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      instr_q   <= 1'b0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      bus_err_q <= 1'b0;
      cause_q   <= CAUSE_NONE;
      eaddr_q   <= '0;
      einstr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      instr_q   <= instr_d;
      rcnt_q    <= rcnt_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      bus_err_q <= bus_err_d;
      cause_q   <= cause_d;
      eaddr_q   <= eaddr_d;
      einstr_q  <= einstr_d;
    end
  end

  assign wbm_cyc_o = (state_q == REQ);
  assign wbm_stb_o = (state_q == REQ);
  assign wbm_we_o  = we_q && (state_q == REQ);
  assign wbm_adr_o = addr_q;
  assign wbm_dat_o = wdata_q;
  assign wbm_sel_o = sel_q;
  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign bus_err   = bus_err_q;
  assign err_cause = cause_q;
  assign err_addr  = eaddr_q;
  assign err_instr = einstr_q;

`ifdef WB_BRIDGE_STATS_EN
  logic [31:0] xfer_q;
  logic [15:0] errc_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      xfer_q <= '0;
      errc_q <= '0;
    end else begin
      if (ready_q && !(&xfer_q))   xfer_q <= xfer_q + 1'b1;
      if (bus_err_q && !(&errc_q)) errc_q <= errc_q + 1'b1;
    end
  end

  assign stat_xfer_cnt = xfer_q;
  assign stat_err_cnt  = errc_q;
`endif

endmodule
